// File: rtl/pqc_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pqc_addsub_pkg
// Brief    : Shared constants and types for the pipelined modular add/sub unit
// Revision : 1.0
// ============================================================================
package pqc_addsub_pkg;

    localparam int Q_KYBER_DEF     = 3329;
    localparam int Q_DILITHIUM_DEF = 8380417;
    localparam int KYBER_LANE_W    = 16;
    localparam int DIL_W           = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Raw stage-1 results; the extra MSB of each field is the carry/borrow.
    typedef struct packed {
        logic [KYBER_LANE_W:0] k_raw1;
        logic [KYBER_LANE_W:0] k_raw0;
        logic [DIL_W:0]        d_raw;
        logic                  sel_kd;
        op_e                   op;
    } stage1_t;

endpackage
`default_nettype wire

// File: rtl/mod_addsub_slice.sv
`default_nettype none
// ============================================================================
// Module   : mod_addsub_slice
// Brief    : Combinational stage-1 (raw add/sub) and stage-2 (correction) logic
//            for one 32-bit slice
// Revision : 1.0
// ============================================================================
module mod_addsub_slice
    import pqc_addsub_pkg::*;
#(
    parameter int Q_KYBER     = Q_KYBER_DEF,
    parameter int Q_DILITHIUM = Q_DILITHIUM_DEF
) (
    input  logic [DIL_W-1:0] i_src_a,
    input  logic [DIL_W-1:0] i_src_b,
    input  logic             i_sel_kd,
    input  op_e              i_op,
    output stage1_t          o_stage1,
    input  stage1_t          i_stage1,
    output logic [DIL_W-1:0] o_result
);

    localparam int KW = KYBER_LANE_W;
    localparam logic [KW-1:0]    C_QK     = Q_KYBER[KW-1:0];
    localparam logic [KW:0]      C_QK_EXT = Q_KYBER[KW:0];
    localparam logic [DIL_W-1:0] C_QD     = Q_DILITHIUM[DIL_W-1:0];
    localparam logic [DIL_W:0]   C_QD_EXT = {1'b0, Q_DILITHIUM[DIL_W-1:0]};

    logic [KW:0]    w_a0, w_a1, w_b0, w_b1;
    logic [DIL_W:0] w_ad, w_bd;

    // Zero-extended lanes keep the Kyber carry chains split at bit 16.
    assign w_a0 = {1'b0, i_src_a[KW-1:0]};
    assign w_a1 = {1'b0, i_src_a[DIL_W-1:KW]};
    assign w_b0 = {1'b0, i_src_b[KW-1:0]};
    assign w_b1 = {1'b0, i_src_b[DIL_W-1:KW]};
    assign w_ad = {1'b0, i_src_a};
    assign w_bd = {1'b0, i_src_b};

    always_comb begin
        o_stage1        = '0;
        o_stage1.sel_kd = i_sel_kd;
        o_stage1.op     = i_op;
        if (i_op == OP_SUB) begin
            o_stage1.k_raw0 = w_a0 - w_b0;
            o_stage1.k_raw1 = w_a1 - w_b1;
            o_stage1.d_raw  = w_ad - w_bd;
        end else begin
            o_stage1.k_raw0 = w_a0 + w_b0;
            o_stage1.k_raw1 = w_a1 + w_b1;
            o_stage1.d_raw  = w_ad + w_bd;
        end
    end

    function automatic logic [KW-1:0] fix_kyber(input logic [KW:0] r, input op_e op);
        if (op == OP_SUB)
            return r[KW] ? (r[KW-1:0] + C_QK) : r[KW-1:0];
        else
            return (r >= C_QK_EXT) ? (r[KW-1:0] - C_QK) : r[KW-1:0];
    endfunction

    function automatic logic [DIL_W-1:0] fix_dil(input logic [DIL_W:0] r, input op_e op);
        if (op == OP_SUB)
            return r[DIL_W] ? (r[DIL_W-1:0] + C_QD) : r[DIL_W-1:0];
        else
            return (r >= C_QD_EXT) ? (r[DIL_W-1:0] - C_QD) : r[DIL_W-1:0];
    endfunction

    always_comb begin
        o_result = '0;
        if (i_stage1.sel_kd)
            o_result = {fix_kyber(i_stage1.k_raw1, i_stage1.op),
                        fix_kyber(i_stage1.k_raw0, i_stage1.op)};
        else
            o_result = fix_dil(i_stage1.d_raw, i_stage1.op);
    end

endmodule
`default_nettype wire

// File: rtl/mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_addsub_pipe
// Brief    : Two-stage pipelined Kyber/Dilithium modular add/sub, valid/ready
// Revision : 1.0
// ============================================================================
module mod_addsub_pipe
    import pqc_addsub_pkg::*;
#(
    parameter int NUM_SLICES  = 1,
    parameter int Q_KYBER     = Q_KYBER_DEF,
    parameter int Q_DILITHIUM = Q_DILITHIUM_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        selKD_i,
    input  logic                        op_i,
    input  logic [DIL_W*NUM_SLICES-1:0] srcA_i,
    input  logic [DIL_W*NUM_SLICES-1:0] srcB_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DIL_W*NUM_SLICES-1:0] result_o,
    output logic                        busy_o
);

    localparam int W = DIL_W * NUM_SLICES;

    stage1_t [NUM_SLICES-1:0] w_stage1;
    stage1_t [NUM_SLICES-1:0] r_stage1;
    logic    [W-1:0]          w_result;
    logic    [W-1:0]          r_result;
    logic                     r_s1_valid;
    logic                     r_s2_valid;
    logic                     w_s1_en;
    logic                     w_s2_en;

    assign w_s2_en     = !r_s2_valid | out_ready_i;
    assign w_s1_en     = !r_s1_valid | w_s2_en;
    assign in_ready_o  = w_s1_en;
    assign out_valid_o = r_s2_valid;
    assign result_o    = r_result;
    assign busy_o      = r_s1_valid | r_s2_valid;

    generate
        for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
            mod_addsub_slice #(
                .Q_KYBER     (Q_KYBER),
                .Q_DILITHIUM (Q_DILITHIUM)
            ) u_slice (
                .i_src_a  (srcA_i[DIL_W*s +: DIL_W]),
                .i_src_b  (srcB_i[DIL_W*s +: DIL_W]),
                .i_sel_kd (selKD_i),
                .i_op     (op_e'(op_i)),
                .o_stage1 (w_stage1[s]),
                .i_stage1 (r_stage1[s]),
                .o_result (w_result[DIL_W*s +: DIL_W])
            );
        end
    endgenerate

    // Each stage loads only when its downstream slot is free; otherwise it holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_stage1   <= '0;
            r_result   <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid_i;
                if (in_valid_i)
                    r_stage1 <= w_stage1;
            end
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_result <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_addsub_pipe
// Brief    : Self-checking bench: vector table, scoreboard and corner sequences
// Revision : 1.0
// ============================================================================
module tb_mod_addsub_pipe;

    localparam int NS = 2;
    localparam int W  = 32 * NS;
    localparam int QK = 3329;
    localparam longint QD = 8380417;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         selKD_i = 1'b0;
    logic         op_i = 1'b0;
    logic [W-1:0] srcA_i = '0;
    logic [W-1:0] srcB_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] result_o;
    logic         busy_o;

    mod_addsub_pipe #(.NUM_SLICES(NS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .selKD_i     (selKD_i),
        .op_i        (op_i),
        .srcA_i      (srcA_i),
        .srcB_i      (srcB_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    int n_waits = 0;
    logic [W-1:0] sb[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sel, input logic op);
        logic [W-1:0] res = '0;
        for (int s = 0; s < NS; s++) begin
            if (sel) begin
                for (int l = 0; l < 2; l++) begin
                    int x = int'(a[32*s+16*l +: 16]);
                    int y = int'(b[32*s+16*l +: 16]);
                    int r = op ? ((x - y + QK) % QK) : ((x + y) % QK);
                    res[32*s+16*l +: 16] = 16'(r);
                end
            end else begin
                longint x = longint'(a[32*s +: 32]);
                longint y = longint'(b[32*s +: 32]);
                longint r = op ? ((x - y + QD) % QD) : ((x + y) % QD);
                res[32*s +: 32] = 32'(r);
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] rand_operand(input logic sel);
        logic [W-1:0] v = '0;
        for (int s = 0; s < NS; s++) begin
            if (sel)
                v[32*s +: 32] = {16'($urandom_range(0, QK-1)), 16'($urandom_range(0, QK-1))};
            else
                v[32*s +: 32] = 32'($urandom_range(0, 32'(QD-1)));
        end
        return v;
    endfunction

    // Scoreboard: sample transfers 2 time units after the falling edge.
    always @(negedge clk_i) begin
        #2;
        if (rst_i) begin
            sb.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, expected no output beat", result_o);
                end else begin
                    check("sb_result", result_o, sb.pop_front());
                end
            end
            if (in_valid_i && in_ready_o)
                sb.push_back(model(srcA_i, srcB_i, selKD_i, op_i));
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel, input logic op);
        int guard = 0;
        in_valid_i = 1'b1;
        srcA_i = a;
        srcB_i = b;
        selKD_i = sel;
        op_i = op;
        #1;
        while (!in_ready_o && guard < 20) begin
            @(negedge clk_i);
            #1;
            guard++;
            n_waits++;
        end
        if (!in_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready_o got 0, expected 1");
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sb.size() != 0 || out_valid_o) && guard < 50) begin
            @(negedge clk_i);
            #3;
            guard++;
        end
        check(name, W'(sb.size()), W'(0));
    endtask

    typedef struct {
        logic        sel;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W-1:0] held;
        int accepted;
        int p0;
        int stale;

        tbl[0] = '{1'b1, 1'b0, {16'd3328, 16'd1},   {16'd3328, 16'd1},   {16'd3327, 16'd2}};
        tbl[1] = '{1'b1, 1'b1, {16'd3000, 16'd100}, {16'd500, 16'd200},  {16'd2500, 16'd3229}};
        tbl[2] = '{1'b0, 1'b0, 32'd8380000,         32'd1000,            32'd583};
        tbl[3] = '{1'b0, 1'b1, 32'd0,               32'd1,               32'd8380416};
        tbl[4] = '{1'b1, 1'b0, 32'd0,               32'd0,               32'd0};
        tbl[5] = '{1'b0, 1'b0, 32'd8380416,         32'd1,               32'd0};
        tbl[6] = '{1'b1, 1'b0, {16'd1664, 16'd3328}, {16'd1665, 16'd1},  32'd0};
        tbl[7] = '{1'b0, 1'b1, 32'd5,               32'd5,               32'd0};
        tbl[8] = '{1'b1, 1'b1, {16'd3328, 16'd0},   {16'd0, 16'd3328},   {16'd3328, 16'd1}};
        tbl[9] = '{1'b0, 1'b1, 32'd100,             32'd8380416,         32'd101};

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid_o), W'(0));
        check("rst_busy",      W'(busy_o),      W'(0));
        check("rst_result",    result_o,        W'(0));
        check("rst_in_ready",  W'(in_ready_o),  W'(1));
        @(negedge clk_i);

        // Table vectors: slice 0 from the table, slice 1 with swapped operands.
        for (int i = 0; i < 10; i++) begin
            drive({tbl[i].b, tbl[i].a}, {tbl[i].a, tbl[i].b}, tbl[i].sel, tbl[i].op);
            #1;
            check("lat_cycle1", W'(out_valid_o), W'(0));
            @(negedge clk_i);
            #1;
            check("lat_cycle2", W'(out_valid_o), W'(1));
            check("tbl_result", W'(result_o[31:0]), W'(tbl[i].exp));
            if (!tbl[i].sel)
                check("dil_upper_zero", W'(result_o[31:23]), W'(0));
            @(negedge clk_i);
        end

        // Back-to-back beats, alternating mode and op.
        n_waits = 0;
        p0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            logic sel;
            sel = i[0];
            drive(rand_operand(sel), rand_operand(sel), sel, i[1]);
        end
        #1;
        check("b2b_no_stall", W'(n_waits), W'(0));
        check("b2b_pops",     W'(n_pops - p0), W'(6));
        check("b2b_valid6",   W'(out_valid_o), W'(1));
        @(negedge clk_i);
        #1;
        check("b2b_valid7",   W'(out_valid_o), W'(1));
        @(negedge clk_i);
        #1;
        check("b2b_idle",     W'(out_valid_o), W'(0));
        drain("b2b_drain");

        // Back-pressure: 4 beats offered, only 2 fit.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            logic sel;
            sel = ~i[0];
            in_valid_i = 1'b1;
            selKD_i = sel;
            op_i = i[1];
            srcA_i = rand_operand(sel);
            srcB_i = rand_operand(sel);
            #1;
            if (in_ready_o) accepted++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        #1;
        check("stall_accepted", W'(accepted),    W'(2));
        check("stall_in_ready", W'(in_ready_o),  W'(0));
        check("stall_valid",    W'(out_valid_o), W'(1));
        held = result_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check("stall_hold", result_o, held);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        check("stall_release_ready", W'(in_ready_o), W'(1));
        p0 = n_pops;
        drain("stall_drain");
        check("stall_pops", W'(n_pops - p0), W'(2));

        // Reset with two beats in flight.
        @(negedge clk_i);
        drive(rand_operand(1'b1), rand_operand(1'b1), 1'b1, 1'b0);
        drive(rand_operand(1'b0), rand_operand(1'b0), 1'b0, 1'b1);
        out_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid_o), W'(0));
        check("mid_rst_busy",      W'(busy_o),      W'(0));
        check("mid_rst_result",    result_o,        W'(0));
        check("mid_rst_in_ready",  W'(in_ready_o),  W'(1));
        out_ready_i = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            #1;
            if (out_valid_o) stale++;
        end
        check("mid_rst_no_stale", W'(stale), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Pipelined, parametrised modular add/subtract unit for the NTT datapath; it is the registered successor to the combinational 32-bit add/sub.
- Processes NUM_SLICES 32-bit slices per beat. Each slice is either two independent 16-bit Kyber lanes (q = Q_KYBER) or one 32-bit Dilithium coefficient (q = Q_DILITHIUM).
- Fully reduces the result into [0, q).
- Sits between the butterfly multiplier output and the coefficient write-back. It uses a valid/ready handshake on both sides and sustains one beat per cycle.

Parameters:
- NUM_SLICES, 1, number of parallel 32-bit slices per beat.
- Q_KYBER, 3329, Kyber modulus, applied per 16-bit lane.
- Q_DILITHIUM, 8380417, Dilithium modulus, applied per 32-bit slice.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  unit can accept an input beat this cycle.
- selKD_i  in  1  mode: 1 = Kyber (2x16-bit lanes per slice), 0 = Dilithium (32-bit per slice).
- op_i  in  1  operation: 0 = A+B mod q, 1 = A-B mod q.
- srcA_i  in  32*NUM_SLICES  operand A. Slice s occupies bits [32s+31:32s].
- srcB_i  in  32*NUM_SLICES  operand B, same layout as srcA_i.
- out_valid_o  out  1  result beat valid.
- out_ready_i  in  1  downstream accepts the result beat.
- result_o  out  32*NUM_SLICES  reduced result, same layout as the operands.
- busy_o  out  1  at least one beat is in flight (s1_valid | s2_valid).

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - s1_valid, s2_valid, out_valid_o and busy_o go to 0.
  - All data and mode/op pipeline registers and result_o go to 0.
  - Any beats in flight are discarded, including a beat mid-pipeline.
  - in_ready_o is 1 in the first cycle after reset deasserts.
- Handshake rules:
  - A beat is accepted when in_valid_i & in_ready_o.
  - A result is taken when out_valid_o & out_ready_i.
  - selKD_i and op_i are sampled together with the operands and travel with the beat. Mode may change on every beat.
- Pipeline control:
  - s2_en = !s2_valid | out_ready_i
  - s1_en = !s1_valid | s2_en
  - in_ready_o = s1_en. This is combinational from out_ready_i; it has no dependence on in_valid_i.
  - While a stage is stalled, its data, valid, mode and op registers hold.
  - out_valid_o stays high and result_o stays stable until the beat is taken.
- Latency: exactly 2 cycles from acceptance to out_valid_o when there is no back-pressure. Throughput is 1 beat/cycle. Beats complete in order.
- Stage 1 (raw arithmetic), per lane:
  - Add: r = a + b, computed one bit wider than the lane.
  - Subtract: r = a - b, computed one bit wider than the lane; the extra bit is the borrow/sign.
  - Kyber: the two 16-bit lanes have independent carry/borrow chains. Nothing propagates from bit 15 into bit 16.
  - Dilithium: a full 32-bit chain per slice.
  - Slices never interact.
- Stage 2 (correction), per lane:
  - Add: if r >= q, output r - q; else output r.
  - Subtract: if the borrow is set, output r + q (truncated to lane width); else output r.
- Operand range contract:
  - Kyber lanes must be < 3329; Dilithium slices must be < 8380417. The result is then exact in [0, q).
  - Out-of-range operands receive exactly one conditional correction. The result is deterministic but unspecified mathematically. The unit raises no error.
- Dilithium upper bits: bits [31:23] of a Dilithium result are 0 whenever the operands are in range.
- Simultaneous events:
  - Accept and output in the same cycle: both the input and the output transfer.
  - A full pipeline with out_ready_i = 1 keeps in_ready_o = 1.

Decomposition:
- Package pqc_addsub_pkg holds:
  - Q_KYBER_DEF and Q_DILITHIUM_DEF constants.
  - op_e enum {OP_ADD, OP_SUB}.
  - Lane width constants KYBER_LANE_W = 16 and DIL_W = 32.
  - A stage-1 struct: raw 17-bit lane results x2, 33-bit Dilithium raw result, selKD, op.
- Sub-module mod_addsub_slice covers one 32-bit slice:
  - Contains the combinational stage-1 and stage-2 logic for that slice.
  - Instantiated NUM_SLICES times by a generate loop.
- The top-level owns the pipeline registers and the handshake.

Test Plan:
- Kyber add, lane1 = 3328 + 3328, lane0 = 1 + 1 -> result lane1 = 3327, lane0 = 2. out_valid_o rises exactly 2 cycles after acceptance. No carry crosses between lanes.
- Kyber sub, lane0 = 100 - 200, lane1 = 3000 - 500 -> lane0 = 3229, lane1 = 2500.
- Dilithium add 8380000 + 1000 -> 583. Dilithium sub 0 - 1 -> 8380416. Bits [31:23] of both results are 0.
- Back-to-back beats with alternating selKD_i/op_i, out_ready_i held at 1 -> one result per cycle, in order, each reduced with its own beat's mode and op.
- Hold out_ready_i = 0 and offer 4 beats -> 2 beats accepted, then in_ready_o = 0. result_o is stable while stalled. After out_ready_i = 1, both results drain in order and in_ready_o = 1 again.
- Assert rst_i for 1 cycle while 2 beats are in flight -> next cycle out_valid_o = 0, busy_o = 0, result_o = 0, in_ready_o = 1. No stale beat appears afterwards.
